// File: rtl/muldiv_sched.sv
// -----------------------------------------------------------------------------
// muldiv_sched
//
// Purpose
//   Sequences one mult/multu/div/divu instruction from the EX stage onto an
//   external multi-cycle multiplier or divider. While the unit works, the
//   pipeline is stalled. The 64-bit result is written to HI/LO for exactly one
//   cycle. A flush (annul) or a watchdog timeout abandons the operation
//   without a HI/LO write.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   req_valid/op/src1/src2   instruction offered by EX (op: 00 mult, 01 multu,
//                            10 div, 11 divu)
//   annul                    flush of the EX instruction
//   stallreq                 stall request to the pipeline stall controller
//   mul_start/signed/a/b     multiplier controls and operands
//   mul_ready/result         multiplier done flag and {hi,lo}
//   div_start/signed/annul   divider controls
//   div_op1/op2              dividend / divisor
//   div_ready/result         divider done flag and {remainder,quotient}
//   hilo_we, hi/lo_wdata     HI/LO write port
//   timeout_err              sticky abort flag, cleared only by reset
//   o_dbg_state              current FSM state (0 IDLE, 1 MUL_RUN, 2 DIV_RUN,
//                            3 DONE)
//
// Handshake
//   A request is accepted on a rising edge where the FSM is IDLE, req_valid=1
//   and annul=0; stallreq is high in that same cycle so EX holds the
//   instruction until the result is ready. Towards a unit, start is a level
//   held high for the whole RUN phase; the first cycle with that unit's
//   ready=1 (and no annul) delivers the result, and start drops the next
//   cycle. Requests seen outside IDLE are ignored.
// -----------------------------------------------------------------------------
module muldiv_sched #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        annul,
    output logic        stallreq,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ready,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        timeout_err,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MUL_RUN = 2'd1;
    localparam logic [1:0] S_DIV_RUN = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [1:0]  r_op;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [63:0] r_result;
    logic [5:0]  r_cnt;
    logic        r_timeout_err;

    logic        w_accept;
    logic        w_div_zero;
    logic        w_in_run;
    logic        w_ready;
    logic        w_tmo;

    assign w_accept   = (r_state == S_IDLE) && req_valid && !annul;
    assign w_div_zero = req_op[1] && (req_src2 == 32'd0);
    assign w_in_run   = (r_state == S_MUL_RUN) || (r_state == S_DIV_RUN);
    // The latched op selects which unit's done flag we are waiting on.
    assign w_ready    = w_in_run && (r_op[1] ? div_ready : mul_ready);
    // The counter holds the number of RUN cycles already completed, so the
    // abort fires in the TIMEOUT-th RUN cycle. annul and ready take priority.
    assign w_tmo      = w_in_run && !annul && !w_ready &&
                        (({1'b0, r_cnt} + 7'd1) == 7'(TIMEOUT));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!req_op[1]) begin
                        w_next = S_MUL_RUN;
                    end else if (w_div_zero) begin
                        // Zero divisor never reaches the divider.
                        w_next = S_DONE;
                    end else begin
                        w_next = S_DIV_RUN;
                    end
                end
            end
            S_MUL_RUN, S_DIV_RUN: begin
                if (annul || w_tmo) begin
                    w_next = S_IDLE;
                end else if (w_ready) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op          <= 2'd0;
            r_src1        <= 32'd0;
            r_src2        <= 32'd0;
            r_result      <= 64'd0;
            r_cnt         <= 6'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= req_op;
                r_src1 <= req_src1;
                r_src2 <= req_src2;
                r_cnt  <= 6'd0;
                if (w_div_zero) begin
                    r_result <= {req_src1, 32'hFFFF_FFFF};
                end
            end
            if (w_in_run) begin
                r_cnt <= r_cnt + 6'd1;
                if (w_ready && !annul) begin
                    r_result <= r_op[1] ? div_result : mul_result;
                end
            end
            if (w_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        // stallreq depends on live inputs, so it is gated by reset explicitly.
        stallreq   = resetn && (w_accept || w_in_run);
        mul_start  = 1'b0;
        mul_signed = 1'b0;
        mul_a      = 32'd0;
        mul_b      = 32'd0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_annul  = 1'b0;
        div_op1    = 32'd0;
        div_op2    = 32'd0;
        hilo_we    = 1'b0;
        hi_wdata   = 32'd0;
        lo_wdata   = 32'd0;
        case (r_state)
            S_MUL_RUN: begin
                mul_start  = 1'b1;
                mul_signed = ~r_op[0];
                mul_a      = r_src1;
                mul_b      = r_src2;
            end
            S_DIV_RUN: begin
                div_start  = 1'b1;
                div_signed = ~r_op[0];
                div_op1    = r_src1;
                div_op2    = r_src2;
                div_annul  = annul || w_tmo;
            end
            S_DONE: begin
                if (!annul) begin
                    hilo_we  = 1'b1;
                    hi_wdata = r_result[63:32];
                    lo_wdata = r_result[31:0];
                end
            end
            default: begin
            end
        endcase
    end

    assign timeout_err = r_timeout_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_sched.sv
`timescale 1ns/1ps
module tb_muldiv_sched;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        annul;
    logic        stallreq;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic        div_annul;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_ready;
    logic [63:0] div_result;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        timeout_err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    muldiv_sched dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .annul       (annul),
        .stallreq    (stallreq),
        .mul_start   (mul_start),
        .mul_signed  (mul_signed),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .mul_result  (mul_result),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_annul   (div_annul),
        .div_op1     (div_op1),
        .div_op2     (div_op2),
        .div_ready   (div_ready),
        .div_result  (div_result),
        .hilo_we     (hilo_we),
        .hi_wdata    (hi_wdata),
        .lo_wdata    (lo_wdata),
        .timeout_err (timeout_err),
        .o_dbg_state (dbg_state)
    );

    logic [199:0] all_outs;
    assign all_outs = {stallreq, mul_start, mul_signed, mul_a, mul_b, div_start,
                       div_signed, div_annul, div_op1, div_op2, hilo_we,
                       hi_wdata, lo_wdata, timeout_err};

    // ---------------- unit models ----------------
    int mul_lat   = 32;
    int div_lat   = 10;
    bit div_never = 1'b0;
    int mul_cnt   = 0;
    int div_cnt   = 0;

    always @(posedge clk) begin
        mul_cnt <= mul_start ? mul_cnt + 1 : 0;
        div_cnt <= div_start ? div_cnt + 1 : 0;
    end

    always_comb begin
        mul_ready = mul_start && (mul_cnt == mul_lat - 1);
        if (mul_signed) begin
            mul_result = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        end else begin
            mul_result = {32'd0, mul_a} * {32'd0, mul_b};
        end
        div_ready  = div_start && !div_never && (div_cnt == div_lat - 1);
        div_result = 64'd0;
        if (div_op2 != 32'd0) begin
            if (div_signed) begin
                div_result = {$signed(div_op1) % $signed(div_op2),
                              $signed(div_op1) / $signed(div_op2)};
            end else begin
                div_result = {div_op1 % div_op2, div_op1 / div_op2};
            end
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    int          n_we = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (hilo_we === 1'b1) begin
                n_we++;
                chk_b("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk_d("hilo_data", {hi_wdata, lo_wdata}, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int          n_stall;
    logic        saw_mul;
    logic        saw_div;
    logic        saw_dann;
    logic        sgn_mul;
    logic        sgn_div;
    logic [31:0] run_a;
    logic [31:0] run_b;

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Follows an operation from its request cycle until stallreq falls,
    // recording what the unit interface showed. With junk=1, fresh random
    // requests are offered during every following cycle.
    task automatic track(input string tag, input int max_cycles, input bit junk);
        n_stall  = 0;
        saw_mul  = 1'b0;
        saw_div  = 1'b0;
        saw_dann = 1'b0;
        sgn_mul  = 1'b0;
        sgn_div  = 1'b0;
        run_a    = 32'd0;
        run_b    = 32'd0;
        for (int i = 0; i < max_cycles && stallreq; i++) begin
            n_stall++;
            if (mul_start) begin
                saw_mul = 1'b1;
                sgn_mul = mul_signed;
                run_a   = mul_a;
                run_b   = mul_b;
            end
            if (div_start) begin
                saw_div = 1'b1;
                sgn_div = div_signed;
                run_a   = div_op1;
                run_b   = div_op2;
            end
            if (div_annul) saw_dann = 1'b1;
            @(negedge clk);
            if (junk) begin
                req_valid = 1'b1;
                req_op    = 2'($urandom_range(0, 3));
                req_src1  = $urandom;
                req_src2  = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            #1;
        end
        req_valid = 1'b0;
        chk_b({tag, "_bounded"}, stallreq, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    int we0;

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_src1  = 32'hFFFF_FFFF;
        req_src2  = 32'h2;
        annul     = 1'b0;
        #12;
        chk_b("rst_stallreq", stallreq, 1'b0);
        chk_b("rst_outputs_zero", |all_outs, 1'b0);
        chk_i("rst_state", int'(dbg_state), 0);
        @(negedge clk);
        req_valid = 1'b0;
        resetn    = 1'b1;
        #1;

        // signed mult -3*5, unit ready after 32 cycles
        mul_lat = 32;
        we0 = n_we;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
        send(2'b00, 32'hFFFF_FFFD, 32'd5);
        chk_b("mul_req_stallreq", stallreq, 1'b1);
        chk_b("mul_req_no_start", mul_start, 1'b0);
        track("mul", 80, 1'b0);
        chk_i("mul_stall_cycles", n_stall, 33);
        chk_b("mul_signed", sgn_mul, 1'b1);
        chk_w("mul_a", run_a, 32'hFFFF_FFFD);
        chk_w("mul_b", run_b, 32'd5);
        chk_b("mul_no_div", saw_div, 1'b0);
        chk_b("mul_done_we", hilo_we, 1'b1);
        idle(2);
        chk_i("mul_writes", n_we - we0, 1);

        // divu 100/7
        div_lat = 10;
        we0 = n_we;
        exp_q.push_back({32'd2, 32'd14});
        send(2'b11, 32'd100, 32'd7);
        track("divu", 40, 1'b0);
        chk_i("divu_stall_cycles", n_stall, 11);
        chk_b("divu_started", saw_div, 1'b1);
        chk_b("divu_signed", sgn_div, 1'b0);
        chk_b("divu_no_annul", saw_dann, 1'b0);
        chk_b("divu_done_we", hilo_we, 1'b1);
        idle(2);
        chk_i("divu_writes", n_we - we0, 1);

        // div by zero short-cut
        we0 = n_we;
        exp_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
        send(2'b10, 32'h0000_1234, 32'd0);
        chk_b("dz_req_stallreq", stallreq, 1'b1);
        track("dz", 10, 1'b0);
        chk_i("dz_stall_cycles", n_stall, 1);
        chk_b("dz_no_div_start", saw_div, 1'b0);
        chk_b("dz_done_we", hilo_we, 1'b1);
        idle(2);
        chk_i("dz_writes", n_we - we0, 1);

        // signed div -7/2 -> q=-3, r=-1
        div_lat = 5;
        we0 = n_we;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        send(2'b10, 32'hFFFF_FFF9, 32'd2);
        track("sdiv", 20, 1'b0);
        chk_i("sdiv_stall_cycles", n_stall, 6);
        chk_b("sdiv_signed", sgn_div, 1'b1);
        idle(2);
        chk_i("sdiv_writes", n_we - we0, 1);

        // multu 7*9 with requests offered during RUN/DONE
        mul_lat = 4;
        we0 = n_we;
        exp_q.push_back({32'd0, 32'd63});
        send(2'b01, 32'd7, 32'd9);
        track("ign", 20, 1'b1);
        chk_i("ign_stall_cycles", n_stall, 5);
        chk_w("ign_a_stable", run_a, 32'd7);
        chk_w("ign_b_stable", run_b, 32'd9);
        chk_b("ign_unsigned", sgn_mul, 1'b0);
        chk_b("ign_done_we", hilo_we, 1'b1);
        idle(2);
        chk_i("ign_writes", n_we - we0, 1);

        // annul in RUN cycle 5 of a divide
        div_lat = 20;
        we0 = n_we;
        send(2'b11, 32'd50, 32'd3);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1;
        chk_i("ann_run_state", int'(dbg_state), 2);
        chk_b("ann_div_annul", div_annul, 1'b1);
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk_i("ann_idle_state", int'(dbg_state), 0);
        chk_b("ann_stallreq", stallreq, 1'b0);
        chk_b("ann_start_dropped", div_start, 1'b0);
        chk_b("ann_div_annul_off", div_annul, 1'b0);
        idle(3);
        chk_i("ann_writes", n_we - we0, 0);

        // annul in the same cycle as ready
        mul_lat = 3;
        we0 = n_we;
        send(2'b01, 32'd4, 32'd5);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk_i("annrdy_state", int'(dbg_state), 0);
        chk_b("annrdy_no_we", hilo_we, 1'b0);
        idle(3);
        chk_i("annrdy_writes", n_we - we0, 0);

        // annul in DONE
        mul_lat = 2;
        we0 = n_we;
        send(2'b01, 32'd3, 32'd3);
        track("anndone", 20, 1'b0);
        chk_i("anndone_stall_cycles", n_stall, 3);
        annul = 1'b1;
        #1;
        chk_i("anndone_state", int'(dbg_state), 3);
        chk_b("anndone_no_we", hilo_we, 1'b0);
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk_i("anndone_idle", int'(dbg_state), 0);
        idle(2);
        chk_i("anndone_writes", n_we - we0, 0);

        // divider never ready -> timeout abort
        div_never = 1'b1;
        we0 = n_we;
        send(2'b10, 32'd9, 32'd3);
        track("tmo", 100, 1'b0);
        chk_i("tmo_stall_cycles", n_stall, 64);
        chk_b("tmo_div_annul", saw_dann, 1'b1);
        chk_b("tmo_err_set", timeout_err, 1'b1);
        chk_i("tmo_state", int'(dbg_state), 0);
        chk_b("tmo_no_we", hilo_we, 1'b0);
        div_never = 1'b0;
        mul_lat = 2;
        exp_q.push_back({32'd0, 32'd42});
        send(2'b01, 32'd6, 32'd7);
        track("tmo_after", 20, 1'b0);
        chk_b("tmo_after_we", hilo_we, 1'b1);
        chk_b("tmo_err_sticky", timeout_err, 1'b1);
        idle(2);
        chk_i("tmo_writes", n_we - we0, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_b("tmo_err_cleared", timeout_err, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        #1;

        // reset in the middle of MUL_RUN, then multu 2*3
        mul_lat = 32;
        we0 = n_we;
        send(2'b00, 32'd16, 32'd32);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk_b("rstrun_busy", mul_start, 1'b1);
        req_valid = 1'b1;
        resetn    = 1'b0;
        #1;
        chk_b("rstrun_outputs_zero", |all_outs, 1'b0);
        chk_i("rstrun_state", int'(dbg_state), 0);
        @(negedge clk);
        resetn    = 1'b1;
        req_valid = 1'b0;
        idle(1);
        mul_lat = 4;
        exp_q.push_back({32'd0, 32'd6});
        send(2'b01, 32'd2, 32'd3);
        track("rstrun_new", 20, 1'b0);
        chk_i("rstrun_new_stall", n_stall, 5);
        chk_b("rstrun_new_we", hilo_we, 1'b1);
        idle(2);
        chk_i("rstrun_writes", n_we - we0, 1);

        // ---------------- final report ----------------
        chk_i("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 Parameter TIMEOUT, default 63: maximum RUN cycles to wait for unit ready before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  EX stage presents a mul/div instruction this cycle.
REQ-005 req_op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 req_src1, req_src2  in  32 each  rs and rt operands.
REQ-007 annul  in  1  flush of the EX instruction; cancels any in-flight operation.
REQ-008 stallreq  out  1  pipeline stall request to the stall controller.
REQ-009 mul_start, mul_signed  out  1 each  multiplier start level and signed select.
REQ-010 mul_a, mul_b  out  32 each  multiplier operands.
REQ-011 mul_ready  in  1; mul_result  in  64  multiplier done flag and {hi,lo} result.
REQ-012 div_start, div_signed, div_annul  out  1 each  divider controls.
REQ-013 div_op1, div_op2  out  32 each  dividend and divisor.
REQ-014 div_ready  in  1; div_result  in  64  divider done flag and {remainder,quotient} result.
REQ-015 hilo_we  out  1; hi_wdata, lo_wdata  out  32 each  HI/LO write port.
REQ-016 timeout_err  out  1  sticky abort flag.

Function
REQ-017 The FSM SHALL have states IDLE, MUL_RUN, DIV_RUN, DONE.
REQ-018 IDLE with req_valid=1 and annul=0: latch req_op, req_src1, req_src2; go to MUL_RUN for op 0x and to DIV_RUN for op 1x; exception in REQ-023.
REQ-019 In MUL_RUN and DIV_RUN, start SHALL be held at 1 and operands and signed SHALL be driven from the latched values; the idle unit's start SHALL be 0 and its operands 0.
REQ-020 In RUN, the first cycle with the unit's ready=1 SHALL capture its 64-bit result, clear start, and go to DONE.
REQ-021 DONE SHALL last exactly one cycle: hilo_we=1, hi_wdata=result[63:32], lo_wdata=result[31:0]; then return to IDLE.
REQ-022 stallreq SHALL be combinational: 1 when (state=IDLE and req_valid and not annul) or state is MUL_RUN or DIV_RUN; 0 otherwise, including DONE.
REQ-023 Divisor zero for div or divu, checked in IDLE: skip DIV_RUN and go directly to DONE with hi=src1 and lo=32'hFFFF_FFFF; div_start stays 0.
REQ-024 annul in RUN: div_annul=1 for that cycle; start is dropped next cycle; the FSM returns to IDLE with no HI/LO write.
REQ-025 annul in DONE: suppress hilo_we for that cycle.
REQ-026 annul and ready in the same cycle: annul wins.
REQ-027 A 6-bit run counter SHALL clear on entry to RUN and increment in each RUN cycle.
REQ-028 When the run counter reaches TIMEOUT with ready=0: set timeout_err, pulse div_annul if in DIV_RUN, and return to IDLE with no write.
REQ-029 timeout_err SHALL clear only on reset.
REQ-030 req_valid in RUN or DONE SHALL be ignored; the latched operands SHALL NOT change until IDLE.
REQ-031 Minimum latency is request cycle T, RUN from T+1, ready at cycle R, hilo_we at R+1; the zero-divisor case writes at T+1.

Reset
REQ-032 resetn=0 SHALL force IDLE at once, independent of clk.
REQ-033 Reset SHALL clear the latched operands, latched result, run counter and timeout_err.
REQ-034 Outputs under reset SHALL be 0: stallreq, starts, signed selects, div_annul, operands, hilo_we, wdata.
REQ-035 Reset during RUN SHALL abandon the operation with no HI/LO write.
REQ-036 After resetn deasserts, the first rising edge SHALL evaluate from IDLE.

Verification
REQ-037 Signed mult -3*5 (src1=FFFFFFFD, src2=5), multiplier model ready after 32 cycles -> mul_signed=1; stallreq high 33 cycles; hilo_we pulse with hi=FFFFFFFF, lo=FFFFFFF1.
REQ-038 divu 100/7 -> div_signed=0, div_start held until ready, then hi=2 and lo=14 written once.
REQ-039 div with src2=0, src1=0x1234 -> no div_start; next cycle hilo_we=1 with hi=0x1234, lo=FFFFFFFF.
REQ-040 annul at RUN cycle 5 of a div -> div_annul pulse, IDLE next cycle, hilo_we never asserted, stallreq low.
REQ-041 Divider model never raises ready, TIMEOUT=63 -> abort after 63 RUN cycles; timeout_err=1 until resetn pulse; no write.
REQ-042 resetn low mid-MUL_RUN -> all outputs 0 immediately; a new multu 2*3 after release completes with hi=0, lo=6.
